// File: rtl/uart_fifoed_recv.sv
// UART receiver (8N1, LSB first) feeding a first-word-fall-through byte FIFO.
// Reports stop-bit framing errors and bytes dropped on a full FIFO.
module uart_fifoed_recv #(
  parameter int CLK_DIV   = 868,
  parameter int DEPTH     = 4096,
  parameter int AFULL_LVL = 4090
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       RX,
  input  logic       dat_rd,
  output logic [7:0] dat,
  output logic       fifo_empty,
  output logic       fifo_afull,
  output logic       fifo_full,
  output logic       frame_err,
  output logic       overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLK_DIV - 1);
  localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   AFULL_CNT = (AW + 1)'(AFULL_LVL);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    WAIT_HI = 3'd4
  } state_t;

  state_t        state_r, state_n_s;
  logic [CW-1:0] cnt_r, cnt_n_s;
  logic [2:0]    bit_r, bit_n_s;
  logic [7:0]    shift_r, shift_n_s;
  logic          rx_meta_r, rx_sync_r, rx_s;
  logic          tick_s, push_req_s, ferr_s, pop_s, push_s, ovr_s;
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [AW:0]   count_r;
  logic [7:0]    mem [DEPTH];

  // Two-flop synchronizer for the asynchronous serial line
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= RX;
      rx_sync_r <= rx_meta_r;
    end
  end

  assign rx_s   = rx_sync_r;
  assign tick_s = (cnt_r == {CW{1'b0}});

  // Receive FSM next-state, baud counter and shift register update
  always_comb begin
    state_n_s  = state_r;
    cnt_n_s    = cnt_r;
    bit_n_s    = bit_r;
    shift_n_s  = shift_r;
    push_req_s = 1'b0;
    ferr_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (!rx_s) begin
          state_n_s = START;
          cnt_n_s   = HALF_LOAD;
        end else begin
          state_n_s = IDLE;
        end
      end
      START, DATA, STOP: begin
        if (!tick_s) begin
          cnt_n_s = cnt_r - CW'(1);
        end else begin
          cnt_n_s = FULL_LOAD;
          if (state_r == START) begin
            // A start bit that is high again at mid-bit was only a glitch
            if (!rx_s) begin
              state_n_s = DATA;
              bit_n_s   = 3'd0;
            end else begin
              state_n_s = IDLE;
            end
          end else if (state_r == DATA) begin
            shift_n_s = {rx_s, shift_r[7:1]};
            if (bit_r == 3'd7) begin
              state_n_s = STOP;
              bit_n_s   = 3'd0;
            end else begin
              bit_n_s = bit_r + 3'd1;
            end
          end else begin
            if (rx_s) begin
              push_req_s = 1'b1;
              state_n_s  = IDLE;
            end else begin
              ferr_s    = 1'b1;
              state_n_s = WAIT_HI;
            end
          end
        end
      end
      WAIT_HI: begin
        if (rx_s) begin
          state_n_s = IDLE;
        end else begin
          state_n_s = WAIT_HI;
        end
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
  end

  // A full FIFO still accepts a byte when a pop frees a slot in the same cycle
  assign pop_s  = dat_rd && (count_r != {(AW + 1){1'b0}});
  assign push_s = push_req_s && ((count_r != DEPTH_CNT) || pop_s);
  assign ovr_s  = push_req_s && !push_s;

  // Receiver state, FIFO pointers/count and event pulse registers
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      cnt_r     <= {CW{1'b0}};
      bit_r     <= 3'd0;
      shift_r   <= 8'h00;
      wr_ptr_r  <= {AW{1'b0}};
      rd_ptr_r  <= {AW{1'b0}};
      count_r   <= {(AW + 1){1'b0}};
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_r   <= state_n_s;
      cnt_r     <= cnt_n_s;
      bit_r     <= bit_n_s;
      shift_r   <= shift_n_s;
      frame_err <= ferr_s;
      overrun   <= ovr_s;
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW + 1)'(1);
        2'b01:   count_r <= count_r - (AW + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage, intentionally not reset
  always_ff @(posedge clk_100MHz) begin
    if (push_s) mem[wr_ptr_r] <= shift_r;
  end

  assign fifo_empty = (count_r == {(AW + 1){1'b0}});
  assign fifo_afull = (count_r >= AFULL_CNT);
  assign fifo_full  = (count_r == DEPTH_CNT);
  assign dat        = fifo_empty ? 8'h00 : mem[rd_ptr_r];

endmodule

// File: doc/uart_fifoed_recv.md
UART_FIFOED_RECV -- requirements
Module: uart_fifoed_recv

Interface
REQ-001 Parameter CLK_DIV, default 868, is the number of clk_100MHz cycles per bit (115200 baud at 100 MHz).
REQ-002 Parameter DEPTH, default 4096, is the number of FIFO entries (power of two).
REQ-003 Parameter AFULL_LVL, default 4090, is the occupancy at which fifo_afull asserts.
REQ-004 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-low.
REQ-005 Port clk_100MHz, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 Port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-007 Port RX, input, 1 bit: asynchronous serial line, idles high.
REQ-008 Port dat_rd, input, 1 bit: pop request; one byte is consumed per cycle that it is high while fifo_empty=0.
REQ-009 Port dat, output, 8 bits: oldest FIFO byte (first-word-fall-through); 8'h00 while fifo_empty=1.
REQ-010 Port fifo_empty, output, 1 bit: count==0.
REQ-011 Port fifo_afull, output, 1 bit: count>=AFULL_LVL.
REQ-012 Port fifo_full, output, 1 bit: count==DEPTH.
REQ-013 Port frame_err, output, 1 bit: one-cycle pulse when a stop bit is sampled low.
REQ-014 Port overrun, output, 1 bit: one-cycle pulse when a good byte is dropped because the FIFO is full.

Function
REQ-015 RX SHALL pass through a 2-flop synchronizer (reset value 1); all decisions use the synchronized value rx_s.
REQ-016 The FSM SHALL have the states IDLE, START, DATA, STOP and WAIT_HI.
REQ-017 IDLE, rx_s==0: go to START and load the baud counter with CLK_DIV/2-1 (433).
REQ-018 Baud counter behaviour: decrements each cycle outside IDLE and WAIT_HI; on reaching 0 (a "tick") the current state acts and the counter reloads with CLK_DIV-1.
REQ-019 START tick, rx_s==0: go to DATA with bit index 0.
REQ-020 START tick, rx_s==1: treat as a glitch and return to IDLE; no push and no flags.
REQ-021 DATA tick: shift rx_s into the MSB of an 8-bit shift register (shifting right), so bytes are received LSB first; after the 8th tick go to STOP.
REQ-022 STOP tick, rx_s==1: push the shift register into the FIFO and go to IDLE.
REQ-023 STOP tick, rx_s==0: pulse frame_err, discard the byte and go to WAIT_HI.
REQ-024 WAIT_HI: go to IDLE on the first cycle with rx_s==1; a break condition produces no further frames.
REQ-025 Push condition: a push SHALL occur when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
REQ-026 Overrun: otherwise the byte is dropped, overrun pulses, and FIFO contents are unchanged.
REQ-027 Pop: dat_rd with fifo_empty=1 SHALL be ignored, with no pointer or count change.
REQ-028 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-029 Read and write pointers SHALL be log2(DEPTH) bits wide and wrap from DEPTH-1 to 0; count SHALL be log2(DEPTH)+1 bits wide.
REQ-030 Latency: a byte pushed on a stop tick SHALL be visible on dat, with fifo_empty=0, on the following cycle.
REQ-031 Stop tick timing: the stop tick SHALL occur 9.5*CLK_DIV (+/-2) cycles after the synchronized falling edge of the start bit.
REQ-032 frame_err and overrun SHALL be registered outputs, high for exactly one cycle per event.

Reset
REQ-033 While reset==0, the block SHALL hold: state=IDLE, counter=0, bit index=0, shift=0, pointers=0, count=0, synchronizer=1.
REQ-034 Output values during reset: fifo_empty=1, fifo_afull=0, fifo_full=0, frame_err=0, overrun=0, dat=8'h00.
REQ-035 Reset asserted mid-frame SHALL abort the frame with no push; FIFO memory contents need not be cleared.
REQ-036 After reset release, the block SHALL remain in IDLE until rx_s==0 is seen.

Verification
REQ-037 Scenario: drive byte 8'hA5 at CLK_DIV=868 -> exactly one push; dat=8'hA5; fifo_empty=0; frame_err=0; overrun=0.
REQ-038 Scenario: send bytes 8'h00, 8'hFF, 8'h55 back-to-back, then pulse dat_rd three times -> dat reads 00, FF, 55 in order; fifo_empty=1 afterwards.
REQ-039 Scenario: drive a 200-cycle low glitch on RX -> no push and no frame_err; the FSM returns to IDLE.
REQ-040 Scenario: drive byte 8'h3C with the stop bit low, held low for 20 bit times -> one frame_err pulse; no push; the next good frame 8'h12 is received correctly.
REQ-041 Scenario: with DEPTH=8 and AFULL_LVL=6, send 9 bytes without reading -> fifo_afull after the 6th; fifo_full after the 8th; overrun pulse on the 9th; the first 8 bytes read back intact.
REQ-042 Scenario: with DEPTH=8, fill the FIFO, then assert dat_rd on the stop-tick cycle of a 9th byte -> no overrun; count stays 8; read and write pointers wrap correctly.
